// File: rtl/sine_wave_nco.sv
// Purpose: phase-accumulator NCO with quarter-wave sine ROM, 10-bit offset-binary output.
// Latency: phase register value -> data_sin in 3 cycles; run -> data_valid in 3 cycles.
// Backpressure: none; the pipeline advances every cycle and never stalls.
//
// Ports:
//   Clk        - system clock, all state on the rising edge
//   ResetN     - synchronous active-low reset
//   run        - accumulate enable
//   fcw        - unsigned phase increment, zero-extended to ACC_W
//   data_sin   - sine sample, offset binary (midscale 512), range 1..1023
//   data_valid - sample was produced from a phase advanced under run=1
//   phase      - current accumulator value (debug)
module sine_wave_nco #(
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 10
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             run,
    input  logic [7:0]       fcw,
    output logic [OUT_W-1:0] data_sin,
    output logic             data_valid,
    output logic [ACC_W-1:0] phase
);

    localparam int  IDX_W   = LUT_AW + 2;
    localparam int  ROM_N   = 2 ** LUT_AW;
    localparam int  AMP_W   = OUT_W - 1;
    localparam real PI      = 3.14159265358979323846;
    localparam logic [OUT_W-1:0] MIDSCALE = OUT_W'(2 ** (OUT_W - 1));

    // Quarter-wave table, sampled at half-step offsets so that no entry is
    // exactly 0 or full scale; this keeps data_sin inside 1..1023.
    logic [AMP_W-1:0] rom_tbl [ROM_N];

    for (genvar g = 0; g < ROM_N; g++) begin : g_rom
        localparam real ANG = 2.0 * PI * ($itor(g) + 0.5) / $itor(4 * ROM_N);
        localparam int  QV  = $rtoi(511.0 * $sin(ANG) + 0.5);
        assign rom_tbl[g] = AMP_W'(QV);
    end

    logic [IDX_W-1:0]  idx;
    logic [1:0]        quad;
    logic [LUT_AW-1:0] lut_a;

    assign idx   = phase[ACC_W-1 -: IDX_W];
    assign quad  = idx[IDX_W-1 -: 2];
    assign lut_a = idx[LUT_AW-1:0];

    logic [LUT_AW-1:0] s1_addr;
    logic [1:0]        s1_quad;
    logic [AMP_W-1:0]  s2_data;
    logic [1:0]        s2_quad;
    logic [1:0]        vld_sr;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            phase      <= '0;
            s1_addr    <= '0;
            s1_quad    <= '0;
            s2_data    <= '0;
            s2_quad    <= '0;
            data_sin   <= MIDSCALE;
            vld_sr     <= '0;
            data_valid <= 1'b0;
        end else begin
            if (run) begin
                // Overflow carry is dropped, so wrap-around is seamless.
                phase <= phase + ACC_W'(fcw);
            end

            // Odd quadrants walk the table backwards: 255-a is ~a.
            s1_addr <= quad[0] ? ~lut_a : lut_a;
            s1_quad <= quad;

            s2_data <= rom_tbl[s1_addr];
            s2_quad <= s1_quad;

            // Upper half-wave (quad 0/1) above midscale, lower half below.
            if (s2_quad[1]) begin
                data_sin <= MIDSCALE - OUT_W'(s2_data);
            end else begin
                data_sin <= MIDSCALE + OUT_W'(s2_data);
            end

            vld_sr     <= {vld_sr[0], run};
            data_valid <= vld_sr[1];
        end
    end

endmodule

// File: tb/tb_sine_wave_nco.sv
// Purpose: directed self-checking bench for sine_wave_nco (ACC_W=16).
// Latency: checks 3-edge phase->data_sin and run->data_valid lag.
// Backpressure: n/a; inputs driven 1 time unit after each rising edge.
module tb_sine_wave_nco;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        run;
    logic [7:0]  fcw;
    logic [9:0]  data_sin;
    logic        data_valid;
    logic [15:0] phase;

    always #5 Clk = ~Clk;

    sine_wave_nco #(.ACC_W(16), .LUT_AW(8), .OUT_W(10)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .run        (run),
        .fcw        (fcw),
        .data_sin   (data_sin),
        .data_valid (data_valid),
        .phase      (phase)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference sine table and cycle model.
    int          q_tab [256];
    logic [15:0] m_phase;
    logic [15:0] ph_q [4];
    logic        rq [3];
    int          age;
    int          exp_ds;
    logic        exp_dv;

    function automatic int sample_of(input logic [15:0] p);
        logic [9:0] ix;
        int         k;
        ix = p[15:6];
        k  = ix[8] ? 255 - int'(ix[7:0]) : int'(ix[7:0]);
        return ix[9] ? 512 - q_tab[k] : 512 + q_tab[k];
    endfunction

    // Advance one rising edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge Clk);
        if (!ResetN) begin
            m_phase = '0;
            for (int i = 0; i < 4; i++) ph_q[i] = '0;
            for (int i = 0; i < 3; i++) rq[i] = 1'b0;
            age    = 0;
            exp_ds = 512;
            exp_dv = 1'b0;
        end else begin
            if (run) m_phase = m_phase + 16'(fcw);
            ph_q[3] = ph_q[2];
            ph_q[2] = ph_q[1];
            ph_q[1] = ph_q[0];
            ph_q[0] = m_phase;
            rq[2] = rq[1];
            rq[1] = rq[0];
            rq[0] = run;
            if (age < 100) age++;
            exp_ds = (age >= 2) ? sample_of(ph_q[3]) : 512;
            exp_dv = rq[2];
        end
        #1;
    endtask

    task automatic apply_reset();
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; run = 1'b1; fcw = 8'h55;
        tick();
        tick();
        n_checks++;
        if (phase !== 16'h0000) begin n_fail++; $display("FAIL reset_phase got %h want 0000", phase); end
        n_checks++;
        if (data_sin !== 10'd512) begin n_fail++; $display("FAIL reset_ds got %0d want 512", data_sin); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", data_valid); end
        ResetN = 1'b1;
        tick();
        n_checks++;
        if (phase !== 16'h0055) begin n_fail++; $display("FAIL release_phase got %h want 0055", phase); end
        // Low pulse on ResetN strictly between edges must be ignored.
        #2 ResetN = 1'b0;
        #2 ResetN = 1'b1;
        tick();
        n_checks++;
        if (phase !== 16'h00AA) begin n_fail++; $display("FAIL glitch_phase got %h want 00aa", phase); end
    endtask

    task automatic test_quadrants();
        logic [15:0] want_ph [4];
        int          want_ds [4];
        want_ph[0] = 16'h0000; want_ds[0] = 514;
        want_ph[1] = 16'h4000; want_ds[1] = 1023;
        want_ph[2] = 16'h8000; want_ds[2] = 510;
        want_ph[3] = 16'hC000; want_ds[3] = 1;
        run = 1'b1; fcw = 8'd0;
        apply_reset();
        for (int qd = 0; qd < 4; qd++) begin
            if (qd != 0) begin
                fcw = 8'd128;
                for (int i = 0; i < 128; i++) tick();
                fcw = 8'd0;
            end
            for (int i = 0; i < 3; i++) tick();
            n_checks++;
            if (phase !== want_ph[qd]) begin
                n_fail++; $display("FAIL quad%0d_phase got %h want %h", qd, phase, want_ph[qd]);
            end
            n_checks++;
            if (data_sin !== 10'(want_ds[qd])) begin
                n_fail++; $display("FAIL quad%0d_ds got %0d want %0d", qd, data_sin, want_ds[qd]);
            end
            n_checks++;
            if (data_valid !== 1'b1) begin
                n_fail++; $display("FAIL quad%0d_dv got %b want 1", qd, data_valid);
            end
        end
    endtask

    task automatic test_increment();
        run = 1'b0; fcw = 8'd0;
        apply_reset();
        run = 1'b1; fcw = 8'd64;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if (phase !== 16'(64 * k)) begin
                n_fail++; $display("FAIL inc_phase k=%0d got %0d want %0d", k, phase, 64 * k);
            end
            n_checks++;
            if (data_valid !== (k >= 3)) begin
                n_fail++; $display("FAIL inc_dv k=%0d got %b want %b", k, data_valid, (k >= 3));
            end
            n_checks++;
            if (data_sin !== 10'(exp_ds)) begin
                n_fail++; $display("FAIL inc_ds k=%0d got %0d want %0d", k, data_sin, exp_ds);
            end
            if (k == 3) begin
                n_checks++;
                if (data_sin !== 10'd514) begin n_fail++; $display("FAIL inc_first got %0d want 514", data_sin); end
            end
            if (k == 4) begin
                n_checks++;
                if (data_sin !== 10'd517) begin n_fail++; $display("FAIL inc_second got %0d want 517", data_sin); end
            end
        end
    endtask

    task automatic test_wrap();
        run = 1'b1; fcw = 8'd255;
        apply_reset();
        for (int i = 0; i < 257; i++) tick();
        n_checks++;
        if (phase !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_top got %h want ffff", phase); end
        tick();
        n_checks++;
        if (phase !== 16'h00FE) begin n_fail++; $display("FAIL wrap_low got %h want 00fe", phase); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (data_sin !== 10'(exp_ds)) begin
                n_fail++; $display("FAIL wrap_ds i=%0d got %0d want %0d", i, data_sin, exp_ds);
            end
            tick();
        end
    endtask

    task automatic test_run_gating();
        run = 1'b1; fcw = 8'd16;
        apply_reset();
        for (int i = 0; i < 20; i++) tick();
        run = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (phase !== 16'd320) begin n_fail++; $display("FAIL gate_phase k=%0d got %0d want 320", k, phase); end
            n_checks++;
            if (data_valid !== (k < 3)) begin
                n_fail++; $display("FAIL gate_dv k=%0d got %b want %b", k, data_valid, (k < 3));
            end
            n_checks++;
            if (data_sin !== 10'(exp_ds)) begin
                n_fail++; $display("FAIL gate_ds k=%0d got %0d want %0d", k, data_sin, exp_ds);
            end
            if (k >= 3) begin
                n_checks++;
                if (data_sin !== 10'd529) begin n_fail++; $display("FAIL gate_hold k=%0d got %0d want 529", k, data_sin); end
            end
        end
        run = 1'b1;
        tick();
        n_checks++;
        if (phase !== 16'd336) begin n_fail++; $display("FAIL fcw16_phase got %0d want 336", phase); end
        fcw = 8'd32;
        tick();
        n_checks++;
        if (phase !== 16'd368) begin n_fail++; $display("FAIL fcw32_phase got %0d want 368", phase); end
    endtask

    task automatic test_reset_running();
        run = 1'b1; fcw = 8'd200;
        apply_reset();
        for (int i = 0; i < 10; i++) tick();
        ResetN = 1'b0;
        tick();
        n_checks++;
        if (phase !== 16'h0000) begin n_fail++; $display("FAIL rr_phase got %h want 0000", phase); end
        n_checks++;
        if (data_sin !== 10'd512) begin n_fail++; $display("FAIL rr_ds got %0d want 512", data_sin); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rr_dv got %b want 0", data_valid); end
        ResetN = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (phase !== 16'd200) begin n_fail++; $display("FAIL rr_step got %0d want 200", phase); end
            end
            n_checks++;
            if (data_valid !== (k == 3)) begin
                n_fail++; $display("FAIL rr_dv_rise k=%0d got %b want %b", k, data_valid, (k == 3));
            end
        end
        n_checks++;
        if (data_sin !== 10'd514) begin n_fail++; $display("FAIL rr_first got %0d want 514", data_sin); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            q_tab[k] = $rtoi(511.0 * $sin(2.0 * 3.14159265358979323846 * ($itor(k) + 0.5) / 1024.0) + 0.5);
        end
        ResetN = 1'b0; run = 1'b1; fcw = 8'h55;
        test_reset();
        test_quadrants();
        test_increment();
        test_wrap();
        test_run_gating();
        test_reset_running();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
